tx_sample_pacer: RTL and testbench
==================================

# tx_sample_pacer

Rate-pacing stage directly upstream of the TX frontend. Accepts sc16 samples on an AXI-Stream input, buffers them in a small FIFO, and replays them as a strobed `tx_stb`/`tx_i`/`tx_q` stream at a programmable rate. Handles prefill before start, graceful end-of-burst on `tlast`, and underrun, zero-filling the strobed stream.

## Interface
- SR_RATE, 0: settings address of the rate divisor register (16 bits).
- SR_CTRL, 1: settings address of the control register (bit0 enable, [15:8] prefill level).
- FIFO_SIZE, 5: log2 of FIFO depth (depth 32 at default).
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  32  sample, {I[31:16], Q[15:0]}.
- i_tlast  in  1  last sample of burst.
- i_tvalid  in  1  AXI-Stream valid.
- i_tready  out  1  AXI-Stream ready.
- tx_stb  out  1  output sample strobe.
- tx_i  out  16  output I.
- tx_q  out  16  output Q.
- underrun  out  1  one-cycle pulse per underrun event.
- eob_ack  out  1  one-cycle pulse when a `tlast` sample is emitted.
- fifo_level  out  FIFO_SIZE+1  current FIFO occupancy.

## Operation
- Registers: rate[15:0] at SR_RATE, reset 0. Ctrl at SR_CTRL, reset 0: enable=ctrl[0], prefill=ctrl[15:8]. A prefill of 0 is treated as 1; values above depth are clamped to depth.
- FIFO: 33 bits wide ({tlast, data}), depth 2^FIFO_SIZE. `i_tready = enable && !full`, driven from registered occupancy. A push and a pop in the same cycle are legal whenever not full.
- Rate tick: a counter runs 0..rate while enable=1. The tick fires when counter==rate, then the counter returns to 0. rate=0 gives a tick every cycle. The counter is held at 0 while disabled.
- States:
  - IDLE (enable=0): FIFO flushed, outputs zero, no strobes. Setting enable=1 moves to PRIME.
  - PRIME: a strobe is issued on every tick with data 0. When fifo_level >= prefill at a tick, the state moves to RUN; that same tick already pops and emits a FIFO sample.
  - RUN: each tick pops one sample and emits it.
    - Popped entry has tlast=1: pulse eob_ack with that strobe, then go to PRIME (no underrun).
    - Tick with FIFO empty: emit 0, pulse underrun, go to PRIME.
- Clearing enable from any state takes effect on the cycle after the write: state goes to IDLE, FIFO is flushed, and any in-flight `i_tvalid` sample is not accepted.
- A simultaneous tick and settings write uses the old register values for that tick.

## Timing
- Reset values: i_tready=0, tx_stb=0, tx_i=0, tx_q=0, underrun=0, eob_ack=0, fifo_level=0, state IDLE, counter 0, rate=0, ctrl=0.
- Settings latency: a register updates one cycle after set_stb. Enable therefore acts on the second cycle after the write.
- Output latency: tx_stb, tx_i, tx_q, underrun and eob_ack are all registered and assert exactly one cycle after the tick. They are high for one cycle only.
- Strobe spacing: consecutive tx_stb pulses are exactly rate+1 cycles apart while enabled, with no gaps across PRIME/RUN transitions.
- Data timing: between strobes, tx_i/tx_q hold the last emitted value.
- Level timing: fifo_level updates one cycle after a push or pop.
- A reset asserted mid-burst returns all state to reset values on the next edge, and FIFO contents are discarded.

## Test plan
- Basic run: rate=3, prefill=4, enable; push 8 samples (I=n, Q=-n) without tlast.
  - tx_stb every 4 cycles; zeros until level>=4, then I=1..8 in order.
  - After sample 8, exactly one underrun pulse, coincident with a zero sample.
- End of burst: rate=0, prefill=1; push 5 samples with tlast on sample 5.
  - Strobe every cycle; samples 1..5 out.
  - eob_ack pulses coincident with sample 5; underrun never pulses.
- Backpressure: rate=9, depth 32; push 40 samples continuously.
  - i_tready drops when fifo_level=32; no sample is lost or duplicated.
  - fifo_level never exceeds 32.
- Disable mid-run: disable after 10 of 20 samples have been emitted.
  - tx_stb stops two cycles after the write; fifo_level=0.
  - i_tready=0; re-enable restarts in PRIME.
- Reset mid-operation: drive reset_n=0 for one cycle during RUN.
  - All outputs and registers return to reset values on the next edge; no further strobes occur until re-configured.
- Prefill edge cases:
  - prefill=0 behaves as prefill=1.
  - prefill=255 with FIFO_SIZE=5 starts once level reaches 32.

Source files
------------

// File: rtl/tx_sample_pacer_if.sv
// AXI-Stream sc16 sample channel feeding the TX pacer.
// Data layout is {I[31:16], Q[15:0]}; tlast marks the final sample of a burst.
interface tx_sample_pacer_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/tx_sample_pacer.sv
// Buffers AXI-Stream sc16 samples and replays them as a strobed TX stream at a
// programmable rate, with prefill, end-of-burst and zero-filled underrun handling.
//
// state | meaning
// IDLE  | disabled; FIFO flushed, outputs zero, no strobes
// PRIME | strobing zeros on each tick until the FIFO reaches the prefill level
// RUN   | each tick pops and emits one sample
module tx_sample_pacer #(
  parameter logic [7:0] SR_RATE   = 8'd0,
  parameter logic [7:0] SR_CTRL   = 8'd1,
  parameter int         FIFO_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  tx_sample_pacer_if.slave     s_axis,
  output logic                 tx_stb,
  output logic [15:0]          tx_i,
  output logic [15:0]          tx_q,
  output logic                 underrun,
  output logic                 eob_ack,
  output logic [FIFO_SIZE:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_SIZE;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state, state_nxt;

  logic [15:0] rate_reg;
  logic [15:0] ctrl_reg;
  logic        enable;
  logic [31:0] prefill_wide;
  logic [FIFO_SIZE:0] prefill;

  logic [15:0] tick_cnt;
  logic        tick;

  logic [32:0]          mem [DEPTH];
  logic [FIFO_SIZE-1:0] wr_ptr, rd_ptr;
  logic [FIFO_SIZE:0]   count;
  logic                 full, empty, push, pop;
  logic [32:0]          head;
  logic                 level_ok;

  logic emit, und_nxt, eob_nxt;

  logic unused_bits;
  assign unused_bits = ^{set_data[31:16], ctrl_reg[7:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_reg <= '0;
      ctrl_reg <= '0;
    end else if (set_stb) begin
      if (set_addr == SR_RATE) rate_reg <= set_data[15:0];
      if (set_addr == SR_CTRL) ctrl_reg <= set_data[15:0];
    end
  end

  assign enable = ctrl_reg[0];

  // Prefill 0 would start on an empty FIFO, so it behaves as 1; larger than depth could never start.
  always_comb begin
    prefill_wide = {24'd0, ctrl_reg[15:8]};
    if (prefill_wide == 32'd0)
      prefill_wide = 32'd1;
    else if (prefill_wide > 32'(DEPTH))
      prefill_wide = 32'(DEPTH);
    prefill = prefill_wide[FIFO_SIZE:0];
  end

  assign tick = enable && (tick_cnt == rate_reg);

  always_ff @(posedge clk) begin
    if (!reset_n)
      tick_cnt <= '0;
    else if (!enable || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  assign full          = (count == (FIFO_SIZE+1)'(DEPTH));
  assign empty         = (count == '0);
  assign s_axis.tready = enable && !full;
  assign push          = s_axis.tvalid && s_axis.tready;
  assign head          = mem[rd_ptr];
  assign level_ok      = (count >= prefill);
  assign fifo_level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (tick && level_ok) state_nxt = head[32] ? PRIME : RUN;
        RUN:     if (tick && (empty || head[32])) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    emit    = tick && (state != IDLE);
    pop     = emit && (((state == PRIME) && level_ok) || ((state == RUN) && !empty));
    und_nxt = emit && (state == RUN) && empty;
    eob_nxt = pop && head[32];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_stb   <= 1'b0;
      tx_i     <= '0;
      tx_q     <= '0;
      underrun <= 1'b0;
      eob_ack  <= 1'b0;
    end else begin
      tx_stb   <= emit;
      underrun <= und_nxt;
      eob_ack  <= eob_nxt;
      if (!enable) begin
        tx_i <= '0;
        tx_q <= '0;
      end else if (emit) begin
        tx_i <= pop ? head[31:16] : 16'd0;
        tx_q <= pop ? head[15:0]  : 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_tx_sample_pacer.sv
// Directed bench for tx_sample_pacer: prefill, pacing, end-of-burst, underrun,
// backpressure, disable and reset behaviour with hand-derived expectations.
module tb_tx_sample_pacer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        tx_stb, underrun, eob_ack;
  logic [15:0] tx_i, tx_q;
  logic [5:0]  fifo_level;

  tx_sample_pacer_if axis ();

  tx_sample_pacer dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .s_axis(axis), .tx_stb(tx_stb), .tx_i(tx_i),
    .tx_q(tx_q), .underrun(underrun), .eob_ack(eob_ack), .fifo_level(fifo_level)
  );

  int passed = 0;
  int total  = 0;

  int cyc = 0;
  int n_stb, nz_cnt, und_cnt, eob_cnt, und_bad, ready_bad, max_level, full_cyc;
  int          q_cyc[$];
  logic [15:0] q_i[$];
  logic [15:0] q_q[$];
  logic        q_eob[$];
  logic        q_und[$];

  // Record what the DUT registered on each edge, sampled just after the edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (tx_stb === 1'b1) begin
      q_cyc.push_back(cyc);
      q_i.push_back(tx_i);
      q_q.push_back(tx_q);
      q_eob.push_back(eob_ack);
      q_und.push_back(underrun);
      n_stb++;
      if (tx_i != 16'd0 || tx_q != 16'd0) nz_cnt++;
    end
    if (underrun === 1'b1) begin
      und_cnt++;
      if (!(tx_stb === 1'b1 && tx_i == 16'd0 && tx_q == 16'd0)) und_bad++;
    end
    if (eob_ack === 1'b1) eob_cnt++;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (fifo_level == 6'd32 && full_cyc < 0) full_cyc = cyc;
    if (fifo_level == 6'd32 && axis.tready === 1'b1) ready_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    q_cyc.delete(); q_i.delete(); q_q.delete(); q_eob.delete(); q_und.delete();
    n_stb = 0; nz_cnt = 0; und_cnt = 0; eob_cnt = 0; und_bad = 0;
    ready_bad = 0; max_level = 0; full_cyc = -1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  task automatic push(input int n, input logic last);
    int t = 0;
    axis.tdata  = {16'(n), 16'(-n)};
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    while (axis.tready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("push_timeout", axis.tready, 1);
    @(negedge clk);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic disable_and_rate(input logic [15:0] r);
    wr(8'd1, 32'd0);
    idle_cycles(3);
    wr(8'd0, {16'd0, r});
    clear_mon();
  endtask

  // Nonzero strobes must be samples 1..n_exp in order (I=k, Q=-k).
  function automatic int seq_errors(input int n_exp);
    int k = 0;
    int err = 0;
    for (int j = 0; j < q_i.size(); j++) begin
      if (q_i[j] != 16'd0 || q_q[j] != 16'd0) begin
        k++;
        if (q_i[j] != 16'(k) || q_q[j] != 16'(-k)) err++;
      end
    end
    if (k != n_exp) err++;
    return err;
  endfunction

  function automatic int spacing_errors(input int period);
    int err = 0;
    for (int j = 1; j < q_cyc.size(); j++)
      if (q_cyc[j] - q_cyc[j-1] != period) err++;
    return err;
  endfunction

  function automatic int nz_index(input int k);
    int c = 0;
    for (int j = 0; j < q_i.size(); j++) begin
      if (q_i[j] != 16'd0 || q_q[j] != 16'd0) begin
        c++;
        if (c == k) return j;
      end
    end
    return -1;
  endfunction

  int idx, wcyc, t, last_cyc;

  initial begin
    reset_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    axis.tdata = '0; axis.tlast = 1'b0; axis.tvalid = 1'b0;
    clear_mon();
    idle_cycles(3);
    chk("rst_tready", axis.tready, 0);
    chk("rst_tx_stb", tx_stb, 0);
    chk("rst_tx_i", tx_i, 0);
    chk("rst_tx_q", tx_q, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_eob_ack", eob_ack, 0);
    chk("rst_fifo_level", fifo_level, 0);
    reset_n = 1'b1;
    @(negedge clk);
    clear_mon();

    // Disabled: offered samples are refused and nothing is strobed.
    axis.tvalid = 1'b1;
    idle_cycles(6);
    axis.tvalid = 1'b0;
    chk("idle_level", max_level, 0);
    chk("idle_strobes", n_stb, 0);

    // Basic run: rate 3, prefill 4, eight samples then one underrun.
    wr(8'd0, 32'd3);
    clear_mon();
    wr(8'd1, 32'h0401);
    for (int n = 1; n <= 8; n++) push(n, 1'b0);
    idle_cycles(60);
    chk("a_sequence", seq_errors(8), 0);
    chk("a_spacing", spacing_errors(4), 0);
    chk("a_leading_zero", nz_index(1) >= 1, 1);
    chk("a_underrun_count", und_cnt, 1);
    idx = nz_index(8);
    chk("a_underrun_after_8", (idx >= 0 && idx + 1 < q_und.size()) ? q_und[idx+1] : 1'b0, 1);
    chk("a_underrun_zero", und_bad, 0);

    // End of burst: rate 0, prefill 1, tlast on sample 5.
    disable_and_rate(16'd0);
    wr(8'd1, 32'h0101);
    for (int n = 1; n <= 5; n++) push(n, n == 5);
    idle_cycles(15);
    chk("b_sequence", seq_errors(5), 0);
    chk("b_spacing", spacing_errors(1), 0);
    chk("b_eob_count", eob_cnt, 1);
    idx = nz_index(5);
    chk("b_eob_on_5", (idx >= 0) ? q_eob[idx] : 1'b0, 1);
    chk("b_no_underrun", und_cnt, 0);

    // Backpressure: rate 9, forty samples into a 32-deep FIFO.
    disable_and_rate(16'd9);
    wr(8'd1, 32'h0101);
    for (int n = 1; n <= 40; n++) push(n, 1'b0);
    idle_cycles(450);
    chk("c_max_level", max_level, 32);
    chk("c_saw_full", full_cyc >= 0, 1);
    chk("c_ready_when_full", ready_bad, 0);
    chk("c_sequence", seq_errors(40), 0);
    chk("c_spacing", spacing_errors(10), 0);

    // Disable after ten of twenty samples have gone out.
    disable_and_rate(16'd3);
    wr(8'd1, 32'h0101);
    for (int n = 1; n <= 20; n++) push(n, 1'b0);
    t = 0;
    while (nz_cnt < 10 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("d_reached_10", nz_cnt >= 10, 1);
    wcyc = cyc;
    wr(8'd1, 32'd0);
    idle_cycles(10);
    last_cyc = (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] : 0;
    chk("d_stb_stopped", last_cyc <= wcyc + 1, 1);
    chk("d_emitted", nz_cnt, 10);
    chk("d_level", fifo_level, 0);
    chk("d_tready", axis.tready, 0);
    clear_mon();
    wr(8'd1, 32'h0101);
    idle_cycles(20);
    chk("d_restart_strobes", n_stb >= 4, 1);
    chk("d_restart_zeros", nz_cnt, 0);
    chk("d_restart_no_underrun", und_cnt, 0);

    // Reset pulse during RUN.
    disable_and_rate(16'd1);
    wr(8'd1, 32'h0101);
    for (int n = 1; n <= 6; n++) push(n, 1'b0);
    t = 0;
    while (nz_cnt < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("e_running", nz_cnt >= 3, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("e_outputs", {tx_stb, tx_i, tx_q, underrun, eob_ack, axis.tready}, 0);
    chk("e_level", fifo_level, 0);
    clear_mon();
    idle_cycles(20);
    chk("e_no_strobes", n_stb, 0);
    wr(8'd1, 32'h0101);
    idle_cycles(12);
    chk("e_rate_reset", (n_stb >= 5) && (spacing_errors(1) == 0), 1);
    chk("e_fifo_discarded", nz_cnt, 0);

    // Prefill 0 acts as 1.
    disable_and_rate(16'd3);
    wr(8'd1, 32'h0001);
    idle_cycles(16);
    chk("f0_priming", (n_stb >= 3) && (und_cnt == 0), 1);
    push(1, 1'b0);
    idle_cycles(16);
    chk("f0_sequence", seq_errors(1), 0);
    chk("f0_underrun", und_cnt, 1);

    // Prefill 255 clamps to the 32-entry depth.
    disable_and_rate(16'd0);
    wr(8'd1, 32'h0000FF01);
    for (int n = 1; n <= 32; n++) push(n, 1'b0);
    idle_cycles(50);
    chk("f255_reached_full", full_cyc >= 0, 1);
    idx = nz_index(1);
    chk("f255_start", (idx >= 0) ? q_cyc[idx] : -1, full_cyc + 1);
    chk("f255_sequence", seq_errors(32), 0);
    chk("f255_max_level", max_level, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
